key_debounce_bank: RTL and testbench
====================================

# key_debounce_bank

Parametrised multi-channel debouncer for mechanical keys and switches. Each channel is synchronised into the `clk` domain, then filtered by a per-channel stability counter advanced on a shared sample-enable tick. Each channel produces a clean level, single-cycle press/release pulses, and a long-press pulse. It sits between the board key pins and the control/menu logic, replacing the single-channel fixed-count debouncer.

## Interface
- `CHANNELS`, default 4: number of independent key channels, ≥1.
- `STABLE_TICKS`, default 4: consecutive mismatching `en` ticks required to accept a new level, range 1..2^16−1.
- `HOLD_TICKS`, default 0: `en` ticks `key_out` must stay 1 before `hold` pulses. 0 disables `hold`. Range 0..2^16−1.
- `RESET_LEVEL`, default 1'b0: idle level loaded into synchronisers and `key_out` at reset.
- `clk` in 1: single clock. All logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: sample tick from an external prescaler. Tie to 1 to sample every cycle.
- `key_in` in CHANNELS: raw asynchronous key levels.
- `key_out` out CHANNELS: debounced levels.
- `rise` out CHANNELS: 1-cycle pulse when `key_out[i]` goes 0→1.
- `fall` out CHANNELS: 1-cycle pulse when `key_out[i]` goes 1→0.
- `hold` out CHANNELS: 1-cycle pulse when the long-press threshold is reached.

## Operation
- Reset values:
  - synchronisers = `RESET_LEVEL`
  - `key_out` = `RESET_LEVEL`
  - stability and hold counters = 0
  - `rise`, `fall`, `hold` = 0
  - No `rise`/`fall` is produced by reset release.
- Synchroniser: two flops per channel (`s1`, `s2`), clocked every cycle regardless of `en`.
- Per-channel state machine, evaluated only when `en`=1. With `en`=0 all counters hold.
  - **IDLE** (cnt=0, `s2`==`key_out`): stay.
  - **IDLE → COUNT**: `s2`≠`key_out`; cnt ← 1.
  - **COUNT, `s2`==`key_out`** (glitch ended): cnt ← 0, return to IDLE. No output change.
  - **COUNT, `s2`≠`key_out`, cnt+1 < `STABLE_TICKS`**: cnt ← cnt+1.
  - **Accept**: mismatch on the `STABLE_TICKS`-th consecutive tick → `key_out` ← `s2`, cnt ← 0, and `rise` or `fall` for that channel is asserted.
  - `STABLE_TICKS`=1: accept on the first mismatching tick.
- Counter width is 16 bits. The counter never wraps: the compare with `STABLE_TICKS` always fires first.
- Hold counter (when `HOLD_TICKS`>0):
  - Counts `en` ticks while `key_out`=1; the accept tick itself is not counted.
  - Pulses `hold` on the tick it reaches `HOLD_TICKS`, then saturates, so there is one pulse per press.
  - Clears to 0 in the same cycle `key_out` goes to 0.
- Channels are fully independent. Simultaneous accepts on several channels each pulse in the same cycle.

## Timing
- All outputs are registered. `rise`/`fall` assert in the same cycle `key_out` changes and are high for exactly one `clk` cycle, even when `en` stays high.
- Latency, `en`=1 continuously: a clean step on `key_in` appears on `key_out` after 2 + `STABLE_TICKS` rising edges.
- Latency in general: 2 cycles of synchroniser, then `STABLE_TICKS` consecutive `en` ticks.
- A bounce that returns to the old level for ≥1 `en` tick restarts the count from zero.
- `hold` pulses `HOLD_TICKS` `en` ticks after the `rise` cycle. It is never coincident with `rise`.
- `rst` assertion mid-count: counters and all outputs go to reset values asynchronously; a pending accept is discarded.
- After `rst` deassertion, a `key_in` already differing from `RESET_LEVEL` is debounced normally: 2 + `STABLE_TICKS` cycles, then a `rise`/`fall` pulse.

## Structure
- Package `debounce_pkg`:
  - `DEB_CNT_W` = 16.
  - Enum `deb_state_t` {IDLE, COUNT}.
  - Parameter legality checks (`STABLE_TICKS` ≥ 1, both thresholds < 2^`DEB_CNT_W`).
- Sub-module `debounce_channel`: synchroniser, stability FSM, edge pulses, hold counter for one key. The top instantiates it `CHANNELS` times in a generate loop, sharing `clk`, `rst`, `en`.

## Test plan
- **Clean press**: `STABLE_TICKS`=4, `en`=1, `key_in[0]` 0→1 at cycle 10 → `key_out[0]`=1 and `rise[0]`=1 at cycle 16 only; no `fall`; other channels unchanged.
- **Bounce**: `key_in[1]` toggles 1,0,1,0 every 2 cycles, then holds 1 → no `key_out`/`rise` change until 6 cycles after the final edge; exactly one `rise[1]` pulse.
- **Sample enable**: `en` high 1 cycle in 5, `STABLE_TICKS`=3, `key_in[2]` steps to 1 → acceptance on the 3rd `en` tick after synchroniser; the counter holds on `en`=0 cycles.
- **Long press**: `HOLD_TICKS`=8, press held 20 ticks → one `hold` pulse 8 ticks after `rise`. Release then re-press → `hold` fires again. Release at tick 5 → no `hold`.
- **Reset mid-count**: assert `rst` at cnt=3 of 4 → `key_out`=`RESET_LEVEL` immediately, no pulse. Release with `key_in` still 1 → `rise` 6 cycles later.
- **Simultaneous**: all channels step together with `RESET_LEVEL`=1 and `key_in`=0 → all `fall` bits pulse in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared types, constants and parameter-legality helper for
//                the key debouncer bank and its per-channel filter.
//                Contents:
//                  DEB_CNT_W     - width of the stability and hold counters
//                  DEB_CNT_MAX   - largest threshold a counter can represent
//                  deb_state_t   - per-channel stability FSM state
//                  deb_params_ok - elaboration-time threshold check
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  localparam int DEB_CNT_W   = 16;
  localparam int DEB_CNT_MAX = (1 << DEB_CNT_W) - 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  // Thresholds must fit the counter so the compare always fires before the
  // counter could wrap; a zero stability threshold is meaningless.
  function automatic bit deb_params_ok(input int stable_ticks, input int hold_ticks);
    return (stable_ticks >= 1) && (stable_ticks <= DEB_CNT_MAX) &&
           (hold_ticks >= 0)   && (hold_ticks <= DEB_CNT_MAX);
  endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One debounced key. Two-flop synchroniser, stability FSM
//                advanced on the shared sample tick, registered press/release
//                pulses and an optional saturating long-press detector.
//  Ports       : clk     - clock, all logic on rising edge
//                rst     - asynchronous active-high reset
//                en      - sample tick; FSM and counters only move when 1
//                key_in  - raw asynchronous key level
//                key_out - debounced level
//                rise    - 1-cycle pulse on key_out 0->1
//                fall    - 1-cycle pulse on key_out 1->0
//                hold    - 1-cycle pulse when long-press threshold reached
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = 4,
  parameter int   HOLD_TICKS   = 0,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_in,
  output logic key_out,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam logic [DEB_CNT_W-1:0] c_stable      = STABLE_TICKS[DEB_CNT_W-1:0];
  localparam logic [DEB_CNT_W-1:0] c_hold        = HOLD_TICKS[DEB_CNT_W-1:0];
  localparam logic                 c_single_tick = (STABLE_TICKS == 1);
  localparam logic                 c_hold_en     = (HOLD_TICKS != 0);

  // Synchroniser
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Stability filter
  deb_state_t           state_q, state_d;
  logic [DEB_CNT_W-1:0] cnt_q,   cnt_d;
  logic                 key_q,   key_d;

  // Output pulses and long-press counter
  logic                 rise_q,  rise_d;
  logic                 fall_q,  fall_d;
  logic                 hold_q,  hold_d;
  logic [DEB_CNT_W-1:0] hcnt_q,  hcnt_d;

  // Combinational helpers
  logic                 accept;
  logic [DEB_CNT_W-1:0] cnt_inc;
  logic [DEB_CNT_W-1:0] hcnt_inc;

  always_comb begin
    s1_d     = key_in;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    hold_d   = 1'b0;
    hcnt_d   = hcnt_q;
    accept   = 1'b0;
    cnt_inc  = cnt_q + {{(DEB_CNT_W-1){1'b0}}, 1'b1};
    hcnt_inc = hcnt_q + {{(DEB_CNT_W-1){1'b0}}, 1'b1};

    if (en) begin
      case (state_q)
        IDLE: begin
          if (s2_q != key_q) begin
            if (c_single_tick) begin
              accept = 1'b1;
            end else begin
              cnt_d   = {{(DEB_CNT_W-1){1'b0}}, 1'b1};
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (s2_q == key_q) begin
            // Bounce back to the accepted level: restart from scratch.
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_inc < c_stable) begin
            cnt_d = cnt_inc;
          end else begin
            accept = 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    if (accept) begin
      key_d   = s2_q;
      cnt_d   = '0;
      state_d = IDLE;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end

    // Long press: key_q (not key_d) gates counting so the accept tick itself
    // is excluded; the counter clears in the same cycle key_out drops and
    // saturates at the threshold so each press yields one pulse.
    if (key_d == 1'b0) begin
      hcnt_d = '0;
    end else if (c_hold_en && en && key_q && (hcnt_q != c_hold)) begin
      hcnt_d = hcnt_inc;
      hold_d = (hcnt_inc == c_hold);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= RESET_LEVEL;
      s2_q    <= RESET_LEVEL;
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      hold_q  <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign key_out = key_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign hold    = hold_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/key_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_bank
//  Description : Bank of CHANNELS independent key debouncers sharing one
//                clock, reset and sample tick.
//  Ports       : clk     - clock, all logic on rising edge
//                rst     - asynchronous active-high reset
//                en      - shared sample tick from an external prescaler
//                key_in  - [CHANNELS] raw asynchronous key levels
//                key_out - [CHANNELS] debounced levels
//                rise    - [CHANNELS] 1-cycle press pulses
//                fall    - [CHANNELS] 1-cycle release pulses
//                hold    - [CHANNELS] 1-cycle long-press pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_bank
  import debounce_pkg::*;
#(
  parameter int   CHANNELS     = 4,
  parameter int   STABLE_TICKS = 4,
  parameter int   HOLD_TICKS   = 0,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] key_in,
  output logic [CHANNELS-1:0] key_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold
);

  generate
    if (!deb_params_ok(STABLE_TICKS, HOLD_TICKS) || (CHANNELS < 1)) begin : g_bad_params
      $error("key_debounce_bank: illegal CHANNELS/STABLE_TICKS/HOLD_TICKS");
    end
  endgenerate

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_channel #(
        .STABLE_TICKS (STABLE_TICKS),
        .HOLD_TICKS   (HOLD_TICKS),
        .RESET_LEVEL  (RESET_LEVEL)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .key_in  (key_in[i]),
        .key_out (key_out[i]),
        .rise    (rise[i]),
        .fall    (fall[i]),
        .hold    (hold[i])
      );
    end
  endgenerate

endmodule : key_debounce_bank
`default_nettype wire

// File: tb/tb_key_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce_bank
//  Description : Directed self-checking bench for key_debounce_bank.
//                dut_a: STABLE=4, HOLD=8, reset level 0, en tied high.
//                dut_b: STABLE=3, reset level 0, en high 1 cycle in 5.
//                dut_c: STABLE=4, reset level 1, all keys low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic       en_a, en_b, en_c;
  logic [3:0] key_in_a, key_in_b, key_in_c;
  logic [3:0] key_out_a, rise_a, fall_a, hold_a;
  logic [3:0] key_out_b, rise_b, fall_b, hold_b;
  logic [3:0] key_out_c, rise_c, fall_c, hold_c;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  key_debounce_bank #(.CHANNELS(4), .STABLE_TICKS(4), .HOLD_TICKS(8), .RESET_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .key_in(key_in_a),
    .key_out(key_out_a), .rise(rise_a), .fall(fall_a), .hold(hold_a));

  key_debounce_bank #(.CHANNELS(4), .STABLE_TICKS(3), .HOLD_TICKS(0), .RESET_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .key_in(key_in_b),
    .key_out(key_out_b), .rise(rise_b), .fall(fall_b), .hold(hold_b));

  key_debounce_bank #(.CHANNELS(4), .STABLE_TICKS(4), .HOLD_TICKS(0), .RESET_LEVEL(1'b1)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .key_in(key_in_c),
    .key_out(key_out_c), .rise(rise_c), .fall(fall_c), .hold(hold_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; the 1-in-5 tick for dut_b is produced here so that
  // edge k sees en_b=1 exactly when (k-1)%5 == 0.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    en_b = ((cyc % 5) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] acc;
    int         n_rise;
    int         n_fall;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a  = 1'b1; en_b  = 1'b0; en_c  = 1'b1;
    key_in_a = 4'h0; key_in_b = 4'h0; key_in_c = 4'h0;

    repeat (3) tick();
    chk("a_rst_key",    {28'd0, key_out_a}, 32'h0);
    chk("a_rst_pulses", {20'd0, rise_a, fall_a, hold_a}, 32'h0);
    chk("c_rst_key",    {28'd0, key_out_c}, 32'hF);
    chk("c_rst_pulses", {20'd0, rise_c, fall_c, hold_c}, 32'h0);

    // ---------------- clean press on dut_a ch0 ----------------
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) tick();
    chk("a_rel_quiet", {24'd0, key_out_a, rise_a}, 32'h0);
    key_in_a[0] = 1'b1;
    repeat (5) tick();
    chk("press_pre",   {24'd0, key_out_a, rise_a}, 32'h0);
    tick();
    chk("press_key",   {28'd0, key_out_a}, 32'h1);
    chk("press_rise",  {28'd0, rise_a},    32'h1);
    chk("press_fall",  {28'd0, fall_a},    32'h0);
    tick();
    chk("press_rise1", {24'd0, key_out_a, rise_a}, 32'h10);

    // ---------------- long press ----------------
    repeat (6) tick();
    chk("hold_pre",  {28'd0, hold_a}, 32'h0);
    tick();
    chk("hold_hit",  {28'd0, hold_a}, 32'h1);
    tick();
    chk("hold_post", {28'd0, hold_a}, 32'h0);
    acc = 4'h0;
    repeat (12) begin tick(); acc |= hold_a; end
    chk("hold_sat", {28'd0, acc}, 32'h0);

    key_in_a[0] = 1'b0;
    repeat (5) tick();
    chk("rel_pre", {24'd0, key_out_a, fall_a}, 32'h10);
    tick();
    chk("rel_key", {24'd0, key_out_a, fall_a}, 32'h01);

    // Short press: key_out high for only 5 ticks, no hold expected.
    key_in_a[0] = 1'b1;
    repeat (5) tick();
    key_in_a[0] = 1'b0;
    acc = 4'h0; n_rise = 0; n_fall = 0;
    repeat (20) begin
      tick();
      acc |= hold_a;
      n_rise += int'(rise_a[0]);
      n_fall += int'(fall_a[0]);
    end
    chk("short_rise", n_rise, 1);
    chk("short_fall", n_fall, 1);
    chk("short_hold", {28'd0, acc}, 32'h0);

    // Re-press: hold must fire again, exactly 8 ticks after rise.
    key_in_a[0] = 1'b1;
    repeat (6) tick();
    chk("repress_rise", {28'd0, rise_a}, 32'h1);
    repeat (7) tick();
    chk("repress_hold_pre", {28'd0, hold_a}, 32'h0);
    tick();
    chk("repress_hold", {28'd0, hold_a}, 32'h1);

    // ---------------- bounce on ch1 ----------------
    acc = 4'h0;
    key_in_a[1] = 1'b1; repeat (2) begin tick(); acc |= rise_a; end
    key_in_a[1] = 1'b0; repeat (2) begin tick(); acc |= rise_a; end
    key_in_a[1] = 1'b1; repeat (2) begin tick(); acc |= rise_a; end
    key_in_a[1] = 1'b0; repeat (2) begin tick(); acc |= rise_a; end
    key_in_a[1] = 1'b1;
    repeat (5) begin tick(); acc |= rise_a; end
    chk("bounce_quiet", {27'd0, acc[1], key_out_a[1], 3'b000}, 32'h0);
    tick();
    chk("bounce_accept", {30'd0, key_out_a[1], rise_a[1]}, 32'h3);
    n_rise = 0;
    repeat (10) begin tick(); n_rise += int'(rise_a[1]); end
    chk("bounce_single", n_rise, 0);

    // ---------------- reset mid-count on ch3 ----------------
    key_in_a[3] = 1'b1;
    repeat (5) tick();            // ch3 counter now at 3 of 4
    #1 rst_a = 1'b1;
    #1;
    chk("rst_async_key",    {28'd0, key_out_a}, 32'h0);
    chk("rst_async_pulses", {20'd0, rise_a, fall_a, hold_a}, 32'h0);
    repeat (2) tick();
    rst_a = 1'b0;
    repeat (5) tick();
    chk("rst_rel_pre",  {24'd0, key_out_a, rise_a}, 32'h0);
    tick();
    chk("rst_rel_key",  {28'd0, key_out_a}, 32'hB);
    chk("rst_rel_rise", {28'd0, rise_a},    32'hB);

    // ---------------- sample enable on dut_b ch2 ----------------
    repeat (5) begin
      if ((cyc % 5) != 0) tick();
    end
    chk("b_align", cyc % 5, 0);
    key_in_b[2] = 1'b1;
    repeat (15) tick();
    chk("en_pre",  {24'd0, key_out_b, rise_b}, 32'h0);
    tick();
    chk("en_key",  {28'd0, key_out_b}, 32'h4);
    chk("en_rise", {28'd0, rise_b},    32'h4);
    tick();
    chk("en_rise1", {28'd0, rise_b}, 32'h0);

    // ---------------- simultaneous release on dut_c ----------------
    rst_c = 1'b0;
    repeat (5) tick();
    chk("sim_pre",  {24'd0, key_out_c, fall_c}, 32'hF0);
    tick();
    chk("sim_key",  {28'd0, key_out_c}, 32'h0);
    chk("sim_fall", {28'd0, fall_c},    32'hF);
    chk("sim_rise", {28'd0, rise_c},    32'h0);
    tick();
    chk("sim_fall1", {28'd0, fall_c}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_key_debounce_bank
`default_nettype wire
